iopmp_scan_checker: RTL and testbench

IOPMP_SCAN_CHECKER -- requirements
Module: iopmp_scan_checker

---
 rtl/iopmp_scan_checker.sv | 264 ++++++++++++++++++++++++++
 tb/tb_iopmp_scan_checker.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iopmp_scan_checker.sv
// iopmp_scan_checker: IOPMP permission checker that scans the entry table
// ENTRIES_PER_CYCLE entries per cycle. The lowest-index eligible match decides
// the outcome. Denials are kept in a single error record with a sticky
// overflow flag.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   enable_i                     IOPMP enable; when low every request is allowed
//   req_*                        request handshake (addr, sid, type: bit0 R, bit1 W)
//   rsp_*                        response handshake (allow, hit, matching entry)
//   srcmd_i                      SID-to-MD permission bitmap
//   entry_addr_i, entry_cfg_i    flattened entry table
//   rcd_*                        error record outputs; rcd_clear_i is a W1C pulse
module iopmp_scan_checker #(
    parameter  int unsigned PLEN              = 56,
    parameter  int unsigned NR_MD             = 2,
    parameter  int unsigned NR_ENTRIES_PER_MD = 8,
    parameter  int unsigned NR_MASTERS        = 2,
    parameter  int unsigned ENTRIES_PER_CYCLE = 2,
    localparam int unsigned NR_ENTRIES        = NR_MD * NR_ENTRIES_PER_MD,
    localparam int unsigned SID_W             = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1,
    localparam int unsigned ENT_W             = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           enable_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [PLEN-1:0]                req_addr_i,
    input  logic [SID_W-1:0]               req_sid_i,
    input  logic [1:0]                     req_type_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic                           rsp_allow_o,
    output logic                           rsp_hit_o,
    output logic [ENT_W-1:0]               rsp_entry_o,
    input  logic [NR_MASTERS*NR_MD-1:0]    srcmd_i,
    input  logic [NR_ENTRIES*(PLEN-2)-1:0] entry_addr_i,
    input  logic [NR_ENTRIES*8-1:0]        entry_cfg_i,
    output logic                           rcd_valid_o,
    output logic                           rcd_overflow_o,
    output logic [PLEN-1:0]                rcd_addr_o,
    output logic [SID_W-1:0]               rcd_sid_o,
    output logic [1:0]                     rcd_type_o,
    input  logic                           rcd_clear_i
);

    localparam int unsigned AW = PLEN - 2;
    localparam int unsigned K  = ENTRIES_PER_CYCLE;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] A_TOR   = 2'd1;
    localparam logic [1:0] A_NA4   = 2'd2;
    localparam logic [1:0] A_NAPOT = 2'd3;

    localparam logic [ENT_W-1:0] LAST_IDX = ENT_W'(NR_ENTRIES - K);

    logic [1:0]       state, state_n;
    logic [ENT_W-1:0] idx, idx_n;
    logic [PLEN-1:0]  cap_addr, cap_addr_n;
    logic [SID_W-1:0] cap_sid, cap_sid_n;
    logic [1:0]       cap_type, cap_type_n;
    logic [AW-1:0]    cap_word;

    logic             req_ready_n, rsp_valid_n, rsp_allow_n, rsp_hit_n;
    logic [ENT_W-1:0] rsp_entry_n;
    logic             rcd_valid_n, rcd_overflow_n;
    logic [PLEN-1:0]  rcd_addr_n;
    logic [SID_W-1:0] rcd_sid_n;
    logic [1:0]       rcd_type_n;
    logic             deny;

    // Unpacked view of the entry table; only A and {W,R} matter here
    logic [AW-1:0]         ent_addr [NR_ENTRIES];
    logic [4:0]            ent_cfg  [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] ent_md_ok;
    logic [NR_MD-1:0]      sid_md;
    logic [NR_ENTRIES*4-1:0] cfg_spare;
    logic                  unused_cfg;

    assign cap_word = cap_addr[PLEN-1:2];

    // MD permissions of the captured SID
    always_comb begin
        sid_md = '0;
        for (int s = 0; s < int'(NR_MASTERS); s++) begin
            if (cap_sid == SID_W'(s)) sid_md = srcmd_i[s*NR_MD +: NR_MD];
        end
    end

    for (genvar g = 0; g < int'(NR_ENTRIES); g++) begin : g_ent
        assign ent_addr[g]  = entry_addr_i[g*AW +: AW];
        assign ent_cfg[g]   = entry_cfg_i[g*8 +: 5];
        assign ent_md_ok[g] = sid_md[g / NR_ENTRIES_PER_MD];
        assign cfg_spare[g*4 +: 4] = {entry_cfg_i[g*8+5 +: 3], entry_cfg_i[g*8+2]};
    end
    assign unused_cfg = ^cfg_spare;

    // Window match: K comparators over entries idx..idx+K-1, lowest index wins
    logic             win_found;
    logic [ENT_W-1:0] win_entry;
    logic [1:0]       win_rw;
    logic             win_allow;
    logic [ENT_W-1:0] slot_idx;
    logic [AW-1:0]    slot_addr, slot_prev, slot_mask;
    logic [4:0]       slot_cfg;
    logic             slot_match;

    always_comb begin
        win_found  = 1'b0;
        win_entry  = '0;
        win_rw     = 2'b00;
        slot_idx   = '0;
        slot_addr  = '0;
        slot_prev  = '0;
        slot_mask  = '0;
        slot_cfg   = '0;
        slot_match = 1'b0;
        for (int k = 0; k < int'(K); k++) begin
            slot_idx  = idx + ENT_W'(k);
            slot_addr = ent_addr[slot_idx];
            slot_prev = (slot_idx == '0) ? '0 : ent_addr[slot_idx - ENT_W'(1)];
            slot_cfg  = ent_cfg[slot_idx];
            // NAPOT: trailing ones plus the next zero form the don't-care mask
            slot_mask = slot_addr ^ (slot_addr + AW'(1));
            case (slot_cfg[4:3])
                A_TOR:   slot_match = (cap_word >= slot_prev) && (cap_word < slot_addr);
                A_NA4:   slot_match = (cap_word == slot_addr);
                A_NAPOT: slot_match = ((cap_word ^ slot_addr) & ~slot_mask) == '0;
                default: slot_match = 1'b0;
            endcase
            if (!win_found && slot_match && ent_md_ok[slot_idx]) begin
                win_found = 1'b1;
                win_entry = slot_idx;
                win_rw    = slot_cfg[1:0];
            end
        end
    end

    assign win_allow = (cap_type & ~win_rw) == 2'b00;

    // Next-state, response and record logic
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        cap_addr_n  = cap_addr;
        cap_sid_n   = cap_sid;
        cap_type_n  = cap_type;
        rsp_valid_n = rsp_valid_o;
        rsp_allow_n = rsp_allow_o;
        rsp_hit_n   = rsp_hit_o;
        rsp_entry_n = rsp_entry_o;
        deny        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    cap_addr_n = req_addr_i;
                    cap_sid_n  = req_sid_i;
                    cap_type_n = req_type_i;
                    idx_n      = '0;
                    if (!enable_i || req_type_i == 2'b00) begin
                        state_n     = ST_RESP;
                        rsp_valid_n = 1'b1;
                        rsp_allow_n = 1'b1;
                        rsp_hit_n   = 1'b0;
                        rsp_entry_n = '0;
                    end else begin
                        state_n = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (win_found) begin
                    state_n     = ST_RESP;
                    rsp_valid_n = 1'b1;
                    rsp_allow_n = win_allow;
                    rsp_hit_n   = 1'b1;
                    rsp_entry_n = win_entry;
                    deny        = !win_allow;
                end else if (idx == LAST_IDX) begin
                    state_n     = ST_RESP;
                    rsp_valid_n = 1'b1;
                    rsp_allow_n = 1'b0;
                    rsp_hit_n   = 1'b0;
                    rsp_entry_n = '0;
                    deny        = 1'b1;
                end else begin
                    idx_n = idx + ENT_W'(K);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_n     = ST_IDLE;
                    rsp_valid_n = 1'b0;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        req_ready_n = (state_n == ST_IDLE);

        rcd_valid_n    = rcd_valid_o;
        rcd_overflow_n = rcd_overflow_o;
        rcd_addr_n     = rcd_addr_o;
        rcd_sid_n      = rcd_sid_o;
        rcd_type_n     = rcd_type_o;
        // A clear coinciding with a denial frees the slot for the new denial
        if (deny) begin
            if (!rcd_valid_o || rcd_clear_i) begin
                rcd_valid_n    = 1'b1;
                rcd_overflow_n = 1'b0;
                rcd_addr_n     = cap_addr;
                rcd_sid_n      = cap_sid;
                rcd_type_n     = cap_type;
            end else begin
                rcd_overflow_n = 1'b1;
            end
        end else if (rcd_clear_i) begin
            rcd_valid_n    = 1'b0;
            rcd_overflow_n = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            idx            <= '0;
            cap_addr       <= '0;
            cap_sid        <= '0;
            cap_type       <= 2'b00;
            req_ready_o    <= 1'b1;
            rsp_valid_o    <= 1'b0;
            rsp_allow_o    <= 1'b0;
            rsp_hit_o      <= 1'b0;
            rsp_entry_o    <= '0;
            rcd_valid_o    <= 1'b0;
            rcd_overflow_o <= 1'b0;
            rcd_addr_o     <= '0;
            rcd_sid_o      <= '0;
            rcd_type_o     <= 2'b00;
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            cap_addr       <= cap_addr_n;
            cap_sid        <= cap_sid_n;
            cap_type       <= cap_type_n;
            req_ready_o    <= req_ready_n;
            rsp_valid_o    <= rsp_valid_n;
            rsp_allow_o    <= rsp_allow_n;
            rsp_hit_o      <= rsp_hit_n;
            rsp_entry_o    <= rsp_entry_n;
            rcd_valid_o    <= rcd_valid_n;
            rcd_overflow_o <= rcd_overflow_n;
            rcd_addr_o     <= rcd_addr_n;
            rcd_sid_o      <= rcd_sid_n;
            rcd_type_o     <= rcd_type_n;
        end
    end

endmodule

// File: tb/tb_iopmp_scan_checker.sv
// tb_iopmp_scan_checker: directed testbench for iopmp_scan_checker with a
// response scoreboard (expected responses queued at issue, checked by a monitor).
module tb_iopmp_scan_checker;

    localparam int PLEN = 56;
    localparam int AW   = PLEN - 2;
    localparam int NE   = 16;

    typedef struct {
        logic       allow;
        logic       hit;
        logic [3:0] entry;
        int         lat;
        int         accept;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [PLEN-1:0]   req_addr = '0;
    logic              req_sid = 1'b0;
    logic [1:0]        req_type = 2'b00;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic              rsp_allow;
    logic              rsp_hit;
    logic [3:0]        rsp_entry;
    logic [3:0]        srcmd = 4'b1001;
    logic [NE*AW-1:0]  entry_addr = '0;
    logic [NE*8-1:0]   entry_cfg = '0;
    logic              rcd_valid;
    logic              rcd_overflow;
    logic [PLEN-1:0]   rcd_addr;
    logic              rcd_sid;
    logic [1:0]        rcd_type;
    logic              rcd_clear = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t exp_q[$];

    iopmp_scan_checker dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_addr_i     (req_addr),
        .req_sid_i      (req_sid),
        .req_type_i     (req_type),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_allow_o    (rsp_allow),
        .rsp_hit_o      (rsp_hit),
        .rsp_entry_o    (rsp_entry),
        .srcmd_i        (srcmd),
        .entry_addr_i   (entry_addr),
        .entry_cfg_i    (entry_cfg),
        .rcd_valid_o    (rcd_valid),
        .rcd_overflow_o (rcd_overflow),
        .rcd_addr_o     (rcd_addr),
        .rcd_sid_o      (rcd_sid),
        .rcd_type_o     (rcd_type),
        .rcd_clear_i    (rcd_clear)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic set_entry(input int e, input logic [AW-1:0] a, input logic [7:0] c);
        entry_addr[e*AW +: AW] = a;
        entry_cfg[e*8 +: 8]    = c;
    endtask

    // Called #1 after a rising edge; returns #1 after the acceptance edge
    task automatic issue(input logic [PLEN-1:0] a, input logic s, input logic [1:0] t,
                         input bit push, input logic al, input logic hi,
                         input logic [3:0] en, input int lat);
        exp_t x;
        int n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_before_issue", 64'(req_ready), 64'd1);
        if (push) begin
            x.allow = al; x.hit = hi; x.entry = en; x.lat = lat; x.accept = cyc + 1;
            exp_q.push_back(x);
        end
        req_addr = a; req_sid = s; req_type = t; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idle_timeout", 64'(req_ready), 64'd1);
    endtask

    // Response monitor
    bit         seen = 1'b0;
    exp_t       cur;
    logic       hold_allow, hold_hit;
    logic [3:0] hold_entry;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if (!rsp_valid) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                hold_allow = rsp_allow; hold_hit = rsp_hit; hold_entry = rsp_entry;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: got allow=%0b hit=%0b entry=%0d, required no response",
                             rsp_allow, rsp_hit, rsp_entry);
                end else begin
                    cur = exp_q.pop_front();
                    check("rsp_allow", 64'(rsp_allow), 64'(cur.allow));
                    check("rsp_hit", 64'(rsp_hit), 64'(cur.hit));
                    if (cur.hit) check("rsp_entry", 64'(rsp_entry), 64'(cur.entry));
                    check("rsp_latency", 64'(cyc - cur.accept + 1), 64'(cur.lat));
                end
            end else begin
                check("rsp_allow_stable", 64'(rsp_allow), 64'(hold_allow));
                check("rsp_hit_stable", 64'(rsp_hit), 64'(hold_hit));
                check("rsp_entry_stable", 64'(rsp_entry), 64'(hold_entry));
                check("req_ready_low_in_resp", 64'(req_ready), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        set_entry(0, 54'h1000, 8'h19);   // NAPOT R  : 0x4000..0x4007
        set_entry(1, 54'h2000, 8'h1A);   // NAPOT W  : 0x8000..0x8007
        set_entry(2, 54'h3000, 8'h0A);   // TOR W    : [0x8000, 0xC000)
        set_entry(8, 54'h4000, 8'h19);   // NAPOT R  : 0x10000..0x10007

        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rcd_valid", 64'(rcd_valid), 64'd0);
        check("reset_rcd_overflow", 64'(rcd_overflow), 64'd0);
        check("reset_rcd_addr", 64'(rcd_addr), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", 64'(req_ready), 64'd1);

        // Allowed read, first window
        issue(56'h4007, 1'b0, 2'b01, 1, 1'b1, 1'b1, 4'd0, 2);
        wait_idle();

        // SID1 cannot use MD0: full scan, denied and recorded
        issue(56'h4007, 1'b1, 2'b01, 1, 1'b0, 1'b0, 4'd0, 9);
        wait_idle();
        check("rcd_valid_1", 64'(rcd_valid), 64'd1);
        check("rcd_overflow_1", 64'(rcd_overflow), 64'd0);
        check("rcd_addr_1", 64'(rcd_addr), 64'h4007);
        check("rcd_sid_1", 64'(rcd_sid), 64'd1);
        check("rcd_type_1", 64'(rcd_type), 64'd1);

        // TOR write allowed on entry 2
        issue(56'h9400, 1'b0, 2'b10, 1, 1'b1, 1'b1, 4'd2, 3);
        wait_idle();
        check("rcd_overflow_after_allow", 64'(rcd_overflow), 64'd0);

        // TOR read denied: overflow, record kept
        issue(56'h9400, 1'b0, 2'b01, 1, 1'b0, 1'b1, 4'd2, 3);
        wait_idle();
        check("rcd_overflow_2", 64'(rcd_overflow), 64'd1);
        check("rcd_valid_2", 64'(rcd_valid), 64'd1);
        check("rcd_addr_kept", 64'(rcd_addr), 64'h4007);

        rcd_clear = 1'b1;
        @(posedge clk); #1;
        rcd_clear = 1'b0;
        check("rcd_valid_cleared", 64'(rcd_valid), 64'd0);
        check("rcd_overflow_cleared", 64'(rcd_overflow), 64'd0);

        // SID1 hits entry 8 in the fifth window
        issue(56'h10007, 1'b1, 2'b01, 1, 1'b1, 1'b1, 4'd8, 6);
        wait_idle();

        // Disabled: bypass allow
        enable = 1'b0;
        issue(56'h0, 1'b0, 2'b10, 1, 1'b1, 1'b0, 4'd0, 1);
        wait_idle();
        enable = 1'b1;

        // Type 00: bypass allow, nothing recorded
        issue(56'h4007, 1'b1, 2'b00, 1, 1'b1, 1'b0, 4'd0, 1);
        wait_idle();
        check("rcd_valid_after_none", 64'(rcd_valid), 64'd0);

        // NA4 entry 3 at 0x3100
        set_entry(3, 54'h0C40, 8'h11);
        issue(56'h3103, 1'b0, 2'b01, 1, 1'b1, 1'b1, 4'd3, 3);
        wait_idle();
        // Read+write needs both bits: denied, recorded
        issue(56'h3103, 1'b0, 2'b11, 1, 1'b0, 1'b1, 4'd3, 3);
        wait_idle();
        check("rcd_addr_rw", 64'(rcd_addr), 64'h3103);
        check("rcd_type_rw", 64'(rcd_type), 64'd3);

        // Denial with clear in the same cycle captures the new denial
        issue(56'h3108, 1'b0, 2'b01, 1, 1'b0, 1'b0, 4'd0, 9);
        repeat (7) begin
            @(posedge clk); #1;
        end
        rcd_clear = 1'b1;
        @(posedge clk); #1;
        rcd_clear = 1'b0;
        check("rcd_valid_clear_race", 64'(rcd_valid), 64'd1);
        check("rcd_overflow_clear_race", 64'(rcd_overflow), 64'd0);
        check("rcd_addr_clear_race", 64'(rcd_addr), 64'h3108);
        check("rcd_type_clear_race", 64'(rcd_type), 64'd1);
        wait_idle();

        // Backpressure: response held for 5 cycles
        rsp_ready = 1'b0;
        issue(56'h4007, 1'b0, 2'b01, 1, 1'b1, 1'b1, 4'd0, 2);
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("rsp_valid_held", 64'(rsp_valid), 64'd1);
        check("req_ready_held", 64'(req_ready), 64'd0);
        rsp_ready = 1'b1;
        wait_idle();

        // Reset mid-scan drops an in-flight denial
        issue(56'h4007, 1'b1, 2'b01, 0, 1'b0, 1'b0, 4'd0, 0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_allow", 64'(rsp_allow), 64'd0);
        check("rst_rsp_hit", 64'(rsp_hit), 64'd0);
        check("rst_rsp_entry", 64'(rsp_entry), 64'd0);
        check("rst_rcd_valid", 64'(rcd_valid), 64'd0);
        check("rst_rcd_overflow", 64'(rcd_overflow), 64'd0);
        check("rst_rcd_addr", 64'(rcd_addr), 64'd0);
        check("rst_rcd_sid", 64'(rcd_sid), 64'd0);
        check("rst_rcd_type", 64'(rcd_type), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_midscan_reset", 64'(req_ready), 64'd1);
        repeat (12) begin
            @(posedge clk); #1;
        end
        check("no_record_after_reset", 64'(rcd_valid), 64'd0);
        check("no_rsp_after_reset", 64'(rsp_valid), 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
